// File: rtl/rv32i_rename_regfile.sv
// Rename stage + physical register file: RAT, circular free-tag FIFO and
// physical data array with per-tag valid bits. NUM_SRC source lookups and one
// destination allocation per rename beat; tags return to the FIFO at retire.
// Optional build macro RV32I_RF_WB_BYPASS_EN: a source whose tag is being
// written back in the fire cycle returns the writeback data as ready.
module rv32i_rename_regfile #(
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned NUM_PHYS_REGS = 64,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned NUM_SRC       = 2,
  localparam int unsigned AW = $clog2(NUM_ARCH_REGS),
  localparam int unsigned PW = $clog2(NUM_PHYS_REGS)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_rn_vld,
  output logic                      o_rn_rdy,
  input  logic [NUM_SRC*AW-1:0]     i_rn_src_idx,
  input  logic                      i_rn_dst_vld,
  input  logic [AW-1:0]             i_rn_dst_idx,
  output logic                      o_rn_out_vld,
  output logic [NUM_SRC-1:0]        o_src_rdy,
  output logic [NUM_SRC*PW-1:0]     o_src_tag,
  output logic [NUM_SRC*DATA_W-1:0] o_src_data,
  output logic                      o_dst_vld,
  output logic [PW-1:0]             o_dst_tag,
  output logic [PW-1:0]             o_dst_old_tag,
  input  logic                      i_wb_vld,
  input  logic [PW-1:0]             i_wb_tag,
  input  logic [DATA_W-1:0]         i_wb_data,
  input  logic                      i_ret_vld,
  input  logic [PW-1:0]             i_ret_old_tag,
  output logic [PW:0]               o_free_cnt
);

  logic [PW-1:0]            rat       [NUM_ARCH_REGS];
  logic [PW-1:0]            fifo      [NUM_PHYS_REGS];
  logic [DATA_W-1:0]        phys_data [NUM_PHYS_REGS];
  logic [NUM_PHYS_REGS-1:0] phys_vld;
  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic [PW:0]              cnt;

  logic          eff_dst, fire, pop, push, full;
  logic [PW-1:0] head;

  logic [NUM_SRC-1:0]        src_rdy_d;
  logic [NUM_SRC*PW-1:0]     src_tag_d;
  logic [NUM_SRC*DATA_W-1:0] src_data_d;
  logic [AW-1:0]             src_arch;
  logic [PW-1:0]             src_map;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_PHYS_REGS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign eff_dst    = i_rn_dst_vld & (i_rn_dst_idx != '0);
  assign o_rn_rdy   = (cnt != '0) | ~eff_dst;
  assign fire       = i_rn_vld & o_rn_rdy;
  assign pop        = fire & eff_dst;
  assign full       = (cnt == (PW+1)'(NUM_PHYS_REGS));
  assign push       = i_ret_vld & ~full;
  assign head       = fifo[rd_ptr];
  assign o_free_cnt = cnt;

  // Source lookups against the pre-update RAT; x0 is hardwired ready/zero.
  always_comb begin
    src_rdy_d  = '0;
    src_tag_d  = '0;
    src_data_d = '0;
    src_arch   = '0;
    src_map    = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      src_arch = i_rn_src_idx[s*AW +: AW];
      src_map  = rat[src_arch];
      if (src_arch == '0) begin
        src_rdy_d[s] = 1'b1;
      end else begin
        src_tag_d[s*PW +: PW]          = src_map;
        src_rdy_d[s]                   = phys_vld[src_map];
        src_data_d[s*DATA_W +: DATA_W] = phys_data[src_map];
`ifdef RV32I_RF_WB_BYPASS_EN
        if (i_wb_vld && (i_wb_tag == src_map)) begin
          src_rdy_d[s]                   = 1'b1;
          src_data_d[s*DATA_W +: DATA_W] = i_wb_data;
        end
`endif
      end
    end
  end

  // Rename, writeback and free-list state; a pop's valid-clear follows the writeback.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) rat[i] <= PW'(i);
      for (int unsigned i = 0; i < NUM_PHYS_REGS; i++) begin
        fifo[i]      <= (i < NUM_PHYS_REGS - NUM_ARCH_REGS) ? PW'(i + NUM_ARCH_REGS) : '0;
        phys_vld[i]  <= (i < NUM_ARCH_REGS);
        phys_data[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= PW'(NUM_PHYS_REGS - NUM_ARCH_REGS);
      cnt    <= (PW+1)'(NUM_PHYS_REGS - NUM_ARCH_REGS);
    end else begin
      if (i_wb_vld) begin
        phys_vld[i_wb_tag]  <= 1'b1;
        phys_data[i_wb_tag] <= i_wb_data;
      end
      if (pop) begin
        rat[i_rn_dst_idx] <= head;
        phys_vld[head]    <= 1'b0;
        rd_ptr            <= ptr_inc(rd_ptr);
      end
      if (push) begin
        fifo[wr_ptr] <= i_ret_old_tag;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Registered lookup results, valid for exactly one cycle after fire.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_rn_out_vld  <= 1'b0;
      o_dst_vld     <= 1'b0;
      o_src_rdy     <= '0;
      o_src_tag     <= '0;
      o_src_data    <= '0;
      o_dst_tag     <= '0;
      o_dst_old_tag <= '0;
    end else begin
      o_rn_out_vld <= fire;
      o_dst_vld    <= pop;
      if (fire) begin
        o_src_rdy     <= src_rdy_d;
        o_src_tag     <= src_tag_d;
        o_src_data    <= src_data_d;
        o_dst_tag     <= pop ? head : '0;
        o_dst_old_tag <= pop ? rat[i_rn_dst_idx] : '0;
      end
    end
  end

  // Illegal usage: writeback racing the pop of the same tag, retire into a full FIFO.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(pop && i_wb_vld && (i_wb_tag == head)))
        else $error("writeback to tag %0d popped in the same cycle", head);
      assert (!(i_ret_vld && full))
        else $error("retire push into a full free FIFO");
    end
  end

endmodule

// File: tb/tb_rv32i_rename_regfile.sv
// Self-checking bench for rv32i_rename_regfile: directed scenarios with literal
// expectations, then randomized traffic checked against a queue/array model.
module tb_rv32i_rename_regfile;
  localparam int unsigned NA = 32, NP = 64, DW = 32, NSRC = 2;
  localparam int unsigned AW = 5, PW = 6;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 i_rn_vld, o_rn_rdy, i_rn_dst_vld, o_rn_out_vld, o_dst_vld;
  logic [NSRC*AW-1:0]   i_rn_src_idx;
  logic [AW-1:0]        i_rn_dst_idx;
  logic [NSRC-1:0]      o_src_rdy;
  logic [NSRC*PW-1:0]   o_src_tag;
  logic [NSRC*DW-1:0]   o_src_data;
  logic [PW-1:0]        o_dst_tag, o_dst_old_tag, i_wb_tag, i_ret_old_tag;
  logic                 i_wb_vld, i_ret_vld;
  logic [DW-1:0]        i_wb_data;
  logic [PW:0]          o_free_cnt;

  rv32i_rename_regfile #(.NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP), .DATA_W(DW), .NUM_SRC(NSRC)) dut (
    .clk(clk), .rstn(rstn), .i_rn_vld(i_rn_vld), .o_rn_rdy(o_rn_rdy),
    .i_rn_src_idx(i_rn_src_idx), .i_rn_dst_vld(i_rn_dst_vld), .i_rn_dst_idx(i_rn_dst_idx),
    .o_rn_out_vld(o_rn_out_vld), .o_src_rdy(o_src_rdy), .o_src_tag(o_src_tag),
    .o_src_data(o_src_data), .o_dst_vld(o_dst_vld), .o_dst_tag(o_dst_tag),
    .o_dst_old_tag(o_dst_old_tag), .i_wb_vld(i_wb_vld), .i_wb_tag(i_wb_tag),
    .i_wb_data(i_wb_data), .i_ret_vld(i_ret_vld), .i_ret_old_tag(i_ret_old_tag),
    .o_free_cnt(o_free_cnt));

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_fail = 0;

  // Reference model: architectural map, free list as a queue, in-order ROB of old tags.
  logic [PW-1:0] m_rat   [NA];
  logic          m_pvld  [NP];
  logic [DW-1:0] m_pdata [NP];
  logic [PW-1:0] m_free  [$];
  logic [PW-1:0] m_rob   [$];

  // Stimulus for the next beat.
  logic          s_vld, s_dst_vld, s_wb_vld, s_ret_vld;
  logic [AW-1:0] s_src [NSRC];
  logic [AW-1:0] s_dst;
  logic [PW-1:0] s_wb_tag, s_ret_tag;
  logic [DW-1:0] s_wb_data;
  logic          last_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) m_rat[i] = PW'(i);
    for (int i = 0; i < NP; i++) begin
      m_pvld[i]  = (i < NA);
      m_pdata[i] = '0;
    end
    m_free.delete();
    m_rob.delete();
    for (int i = NA; i < NP; i++) m_free.push_back(PW'(i));
  endtask

  task automatic clr_stim();
    s_vld = 0; s_dst_vld = 0; s_wb_vld = 0; s_ret_vld = 0;
    for (int s = 0; s < NSRC; s++) s_src[s] = '0;
    s_dst = '0; s_wb_tag = '0; s_ret_tag = '0; s_wb_data = '0;
  endtask

  // Drive one beat, predict from the model, compare registered outputs on the next negedge.
  task automatic step();
    logic          eff, rdy_m, fire, e_dst_vld;
    logic [PW-1:0] e_tag [NSRC];
    logic          e_rdy [NSRC];
    logic [DW-1:0] e_data [NSRC];
    logic [PW-1:0] e_dst_tag, e_old, t;
    i_rn_vld = s_vld; i_rn_dst_vld = s_dst_vld; i_rn_dst_idx = s_dst;
    for (int s = 0; s < NSRC; s++) i_rn_src_idx[s*AW +: AW] = s_src[s];
    i_wb_vld = s_wb_vld; i_wb_tag = s_wb_tag; i_wb_data = s_wb_data;
    i_ret_vld = s_ret_vld; i_ret_old_tag = s_ret_tag;
    #1;
    eff   = s_dst_vld && (s_dst != 0);
    rdy_m = (m_free.size() != 0) || !eff;
    last_rdy = o_rn_rdy;
    chk("rn_rdy", o_rn_rdy, rdy_m);
    fire      = s_vld && rdy_m;
    e_dst_vld = fire && eff;
    e_dst_tag = '0; e_old = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (s_src[s] == 0) begin
        e_tag[s] = '0; e_rdy[s] = 1'b1; e_data[s] = '0;
      end else begin
        e_tag[s]  = m_rat[s_src[s]];
        e_rdy[s]  = m_pvld[e_tag[s]];
        e_data[s] = m_pdata[e_tag[s]];
`ifdef RV32I_RF_WB_BYPASS_EN
        if (s_wb_vld && s_wb_tag == e_tag[s]) begin
          e_rdy[s] = 1'b1; e_data[s] = s_wb_data;
        end
`endif
      end
    end
    if (e_dst_vld) begin
      e_dst_tag = m_free[0];
      e_old     = m_rat[s_dst];
    end
    if (s_wb_vld) begin
      m_pvld[s_wb_tag]  = 1'b1;
      m_pdata[s_wb_tag] = s_wb_data;
    end
    if (e_dst_vld) begin
      t = m_free.pop_front();
      m_rat[s_dst] = t;
      m_pvld[t]    = 1'b0;
      m_rob.push_back(e_old);
    end
    if (s_ret_vld) m_free.push_back(s_ret_tag);
    @(negedge clk);
    chk("out_vld", o_rn_out_vld, fire);
    chk("dst_vld", o_dst_vld, e_dst_vld);
    chk("free_cnt", o_free_cnt, m_free.size());
    if (fire) begin
      for (int s = 0; s < NSRC; s++) begin
        chk("src_tag", o_src_tag[s*PW +: PW], e_tag[s]);
        chk("src_rdy", o_src_rdy[s], e_rdy[s]);
        if (e_rdy[s]) chk("src_data", o_src_data[s*DW +: DW], e_data[s]);
      end
    end
    if (e_dst_vld) begin
      chk("dst_tag", o_dst_tag, e_dst_tag);
      chk("dst_old_tag", o_dst_old_tag, e_old);
    end
  endtask

  // Reset with a rename request pending: everything must come back cleared.
  task automatic do_reset();
    rstn = 1'b0;
    i_rn_vld = 1'b1; i_rn_dst_vld = 1'b1; i_rn_dst_idx = 5'd5; i_rn_src_idx = '0;
    i_wb_vld = 1'b0; i_ret_vld = 1'b0; i_wb_tag = '0; i_wb_data = '0; i_ret_old_tag = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_vld", o_rn_out_vld, 0);
    chk("rst_dst_vld", o_dst_vld, 0);
    chk("rst_src_rdy", o_src_rdy, 0);
    chk("rst_src_tag", o_src_tag, 0);
    chk("rst_src_data", o_src_data, 0);
    chk("rst_dst_tag", o_dst_tag, 0);
    chk("rst_old_tag", o_dst_old_tag, 0);
    chk("rst_free_cnt", o_free_cnt, NP - NA);
    rstn = 1'b1;
    model_reset();
    clr_stim();
  endtask

  task automatic rand_stim(input int unsigned ret_pct);
    logic pop_will;
    clr_stim();
    s_vld = ($urandom_range(0, 3) != 0);
    for (int s = 0; s < NSRC; s++) s_src[s] = AW'($urandom_range(0, NA - 1));
    s_dst_vld = ($urandom_range(0, 3) != 0);
    s_dst     = AW'($urandom_range(0, NA - 1));
    pop_will  = s_vld && s_dst_vld && (s_dst != 0) && (m_free.size() != 0);
    if ($urandom_range(0, 1) == 1) begin
      s_wb_tag  = ($urandom_range(0, 3) == 0) ? m_rat[s_src[0]] : PW'($urandom_range(0, NP - 1));
      s_wb_data = $urandom;
      s_wb_vld  = !(pop_will && (s_wb_tag == m_free[0]));
    end
    if (m_rob.size() != 0 && $urandom_range(0, 99) < ret_pct) begin
      s_ret_vld = 1'b1;
      s_ret_tag = m_rob.pop_front();
    end
  endtask

  initial begin
    clr_stim();
    rstn = 1'b0;
    do_reset();

    // Basic rename of x5 with sources x1, x2.
    s_vld = 1; s_src[0] = 5'd1; s_src[1] = 5'd2; s_dst_vld = 1; s_dst = 5'd5;
    step();
    chk("t1_src_rdy", o_src_rdy, 2'b11);
    chk("t1_src_data", o_src_data, 0);
    chk("t1_dst_tag", o_dst_tag, 32);
    chk("t1_old_tag", o_dst_old_tag, 5);
    chk("t1_free_cnt", o_free_cnt, 31);
    chk("t1_model_free", m_free.size(), 31);

    // Double rename of x5, pending source, then writeback makes it ready.
    do_reset();
    s_vld = 1; s_dst_vld = 1; s_dst = 5'd5; step();
    s_vld = 1; s_dst_vld = 1; s_dst = 5'd5; step();
    chk("t2_old_tag", o_dst_old_tag, 32);
    clr_stim(); s_vld = 1; s_src[0] = 5'd5; step();
    chk("t2_src_tag", o_src_tag[PW-1:0], 33);
    chk("t2_src_rdy", o_src_rdy[0], 0);
    clr_stim(); s_wb_vld = 1; s_wb_tag = 6'd33; s_wb_data = 32'hDEAD; step();
    clr_stim(); s_vld = 1; s_src[0] = 5'd5; step();
    chk("t2_src_rdy_wb", o_src_rdy[0], 1);
    chk("t2_src_data_wb", o_src_data[DW-1:0], 32'hDEAD);

    // Exhaust the free list; dst request stalls, src-only request still accepted.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      clr_stim(); s_vld = 1; s_dst_vld = 1; s_dst = AW'((i % 31) + 1); step();
    end
    chk("t3_free_zero", o_free_cnt, 0);
    clr_stim(); s_vld = 1; s_dst_vld = 1; s_dst = 5'd7; step();
    chk("t3_rdy_low", last_rdy, 0);
    chk("t3_no_accept", o_rn_out_vld, 0);
    clr_stim(); s_vld = 1; s_src[0] = 5'd3; s_dst = 5'd7; step();
    chk("t3_src_only", o_rn_out_vld, 1);

    // Retire alongside a pop keeps the count; tag 5 comes back after 32..63.
    do_reset();
    s_vld = 1; s_dst_vld = 1; s_dst = 5'd5; step();
    clr_stim(); s_vld = 1; s_dst_vld = 1; s_dst = 5'd6; s_ret_vld = 1; s_ret_tag = 6'd5; step();
    chk("t4_cnt_same", o_free_cnt, 31);
    for (int i = 0; i < 30; i++) begin
      clr_stim(); s_vld = 1; s_dst_vld = 1; s_dst = AW'((i % 20) + 7); step();
    end
    clr_stim(); s_vld = 1; s_dst_vld = 1; s_dst = 5'd9; step();
    chk("t4_reuse_tag5", o_dst_tag, 5);
    chk("t4_free_zero", o_free_cnt, 0);

    // Writeback coincident with a source lookup of the same tag.
    do_reset();
    s_vld = 1; s_dst_vld = 1; s_dst = 5'd5; step();
    clr_stim(); s_vld = 1; s_src[0] = 5'd5; s_wb_vld = 1; s_wb_tag = 6'd32; s_wb_data = 32'h1234; step();
    chk("t5_src_tag", o_src_tag[PW-1:0], 32);
`ifdef RV32I_RF_WB_BYPASS_EN
    chk("t5_bypass_rdy", o_src_rdy[0], 1);
    chk("t5_bypass_data", o_src_data[DW-1:0], 32'h1234);
`else
    chk("t5_no_bypass_rdy", o_src_rdy[0], 0);
`endif

    // x0 destination never allocates; x0 source reads zero even after tag 0 is written.
    do_reset();
    s_wb_vld = 1; s_wb_tag = 6'd0; s_wb_data = 32'hFFFF_FFFF; step();
    clr_stim(); s_vld = 1; s_dst_vld = 1; s_dst = 5'd0; step();
    chk("t6_dst_vld", o_dst_vld, 0);
    chk("t6_free_cnt", o_free_cnt, 32);
    chk("t6_src_rdy", o_src_rdy, 2'b11);
    chk("t6_src_data", o_src_data, 0);

    // Randomized traffic: drain-heavy, retire-heavy, mid-run reset, mixed.
    do_reset();
    for (int i = 0; i < 1000; i++) begin rand_stim(10); step(); end
    for (int i = 0; i < 1000; i++) begin rand_stim(60); step(); end
    s_vld = 1; s_dst_vld = 1; s_dst = 5'd4; step();
    do_reset();
    for (int i = 0; i < 800; i++) begin rand_stim(40); step(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
